// File: rtl/fp16_pack_rnd_if.sv
// fp16_pack_rnd_if
// Bundles the operand-side and result-side handshakes of fp16_pack_rnd.
//   in_valid/in_ready        : operand pair handshake
//   sign_*/exp_*/mant_*      : per-lane sign, 8-bit biased exponent (bias 15),
//                              22-bit 2.20 product mantissa
//   out_valid/out_ready      : result handshake
//   out                      : {hi FP16, lo FP16}
//   flags                    : {overflow, underflow, inexact}, OR of both lanes
// master = producer/consumer side (testbench or upstream), slave = the packer.
interface fp16_pack_rnd_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_lo;
  logic        sign_hi;
  logic [7:0]  exp_lo;
  logic [7:0]  exp_hi;
  logic [21:0] mant_lo;
  logic [21:0] mant_hi;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [2:0]  flags;

  modport master (
    output in_valid, sign_lo, sign_hi, exp_lo, exp_hi, mant_lo, mant_hi, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, sign_lo, sign_hi, exp_lo, exp_hi, mant_lo, mant_hi, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/fp16_pack_rnd.sv
// fp16_pack_rnd
// Takes two (sign, biased exponent, 2.20 mantissa) products, normalises and
// rounds each to FP16 (round-to-nearest-even, no subnormals), and presents
// them packed as {hi, lo} with OR-ed status flags.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fp16_pack_rnd_if.slave (operand and result handshakes)
// One shared normalise/round unit is time-multiplexed: lo lane in NORM0/RND0,
// hi lane in NORM1/RND1. DONE spends one cycle packing the lane results into
// the output registers before raising out_valid.
module fp16_pack_rnd (
  input  logic           clk,
  input  logic           rst_n,
  fp16_pack_rnd_if.slave bus
);

  typedef enum logic [2:0] {IDLE, NORM0, RND0, NORM1, RND1, DONE} state_t;

  state_t             state_q, state_d;
  logic               signLo_q, signLo_d, signHi_q, signHi_d;
  logic signed [9:0]  expLo_q, expLo_d, expHi_q, expHi_d;
  logic [21:0]        mantLo_q, mantLo_d, mantHi_q, mantHi_d;
  logic               stickyLo_q, stickyLo_d, stickyHi_q, stickyHi_d;
  logic [15:0]        resLo_q, resLo_d, resHi_q, resHi_d;
  logic [2:0]         flgLo_q, flgLo_d, flgHi_q, flgHi_d;
  logic [31:0]        out_q, out_d;
  logic [2:0]         flags_q, flags_d;
  logic               outValid_q, outValid_d;

  logic               selHi, selSign, selSticky;
  logic signed [9:0]  selExp;
  logic [21:0]        selMant;

  logic [4:0]         lzc;
  logic               lzcFound;
  logic [21:0]        normMant;
  logic signed [9:0]  normExp;
  logic               normSticky;

  logic               guard, stickyAll, roundUp;
  logic [10:0]        fracSum;
  logic signed [9:0]  finalExp;
  logic [15:0]        laneRes;
  logic [2:0]         laneFlg;

  assign selHi     = (state_q == NORM1) || (state_q == RND1);
  assign selSign   = selHi ? signHi_q   : signLo_q;
  assign selExp    = selHi ? expHi_q    : expLo_q;
  assign selMant   = selHi ? mantHi_q   : mantLo_q;
  assign selSticky = selHi ? stickyHi_q : stickyLo_q;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = outValid_q;
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;

  // Leading-zero count of bits [20:0]; only consulted when bit 21 is clear
  // and the mantissa is nonzero, so the all-zero result is never used.
  always_comb begin
    lzc      = 5'd0;
    lzcFound = 1'b0;
    for (int i = 20; i >= 0; i--) begin
      if (!lzcFound && selMant[i]) begin
        lzc      = 5'(20 - i);
        lzcFound = 1'b1;
      end
    end
  end

  // Normalise so the leading one sits at bit 20. A right shift can only
  // lose one bit, which is folded into the sticky bit.
  always_comb begin
    normMant   = selMant;
    normExp    = selExp;
    normSticky = selSticky;
    if (selMant[21]) begin
      normMant   = {1'b0, selMant[21:1]};
      normExp    = selExp + 10'sd1;
      normSticky = selSticky | selMant[0];
    end else if (selMant != 22'd0) begin
      normMant = selMant << lzc;
      normExp  = selExp - $signed({5'd0, lzc});
    end
  end

  // Round-to-nearest-even on the normalised lane. Bit 20 is the hidden one,
  // so a carry out of the 10-bit fraction means the significand became 2.0:
  // the fraction wraps to zero and the exponent steps up by one.
  always_comb begin
    guard     = selMant[9];
    stickyAll = selSticky | (|selMant[8:0]);
    roundUp   = guard & (stickyAll | selMant[10]);
    fracSum   = {1'b0, selMant[19:10]} + {10'd0, roundUp};
    finalExp  = selExp + $signed({9'd0, fracSum[10]});

    if (selMant == 22'd0) begin
      laneRes = {selSign, 15'h0000};
      laneFlg = 3'b000;
    end else if (finalExp >= 10'sd31) begin
      laneRes = {selSign, 5'h1F, 10'h000};
      laneFlg = 3'b101;
    end else if (finalExp <= 10'sd0) begin
      laneRes = {selSign, 15'h0000};
      laneFlg = 3'b011;
    end else begin
      laneRes = {selSign, finalExp[4:0], fracSum[9:0]};
      laneFlg = {2'b00, guard | stickyAll};
    end
  end

  // Sequencer and register next-state. Operands are only captured in IDLE,
  // so in_valid during processing is simply ignored. In DONE the first cycle
  // packs the results; out_valid then holds until the consumer takes it.
  always_comb begin
    state_d    = state_q;
    signLo_d   = signLo_q;
    signHi_d   = signHi_q;
    expLo_d    = expLo_q;
    expHi_d    = expHi_q;
    mantLo_d   = mantLo_q;
    mantHi_d   = mantHi_q;
    stickyLo_d = stickyLo_q;
    stickyHi_d = stickyHi_q;
    resLo_d    = resLo_q;
    resHi_d    = resHi_q;
    flgLo_d    = flgLo_q;
    flgHi_d    = flgHi_q;
    out_d      = out_q;
    flags_d    = flags_q;
    outValid_d = outValid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d    = NORM0;
          signLo_d   = bus.sign_lo;
          signHi_d   = bus.sign_hi;
          expLo_d    = {{2{bus.exp_lo[7]}}, bus.exp_lo};
          expHi_d    = {{2{bus.exp_hi[7]}}, bus.exp_hi};
          mantLo_d   = bus.mant_lo;
          mantHi_d   = bus.mant_hi;
          stickyLo_d = 1'b0;
          stickyHi_d = 1'b0;
        end
      end
      NORM0: begin
        mantLo_d   = normMant;
        expLo_d    = normExp;
        stickyLo_d = normSticky;
        state_d    = RND0;
      end
      RND0: begin
        resLo_d = laneRes;
        flgLo_d = laneFlg;
        state_d = NORM1;
      end
      NORM1: begin
        mantHi_d   = normMant;
        expHi_d    = normExp;
        stickyHi_d = normSticky;
        state_d    = RND1;
      end
      RND1: begin
        resHi_d = laneRes;
        flgHi_d = laneFlg;
        state_d = DONE;
      end
      DONE: begin
        if (!outValid_q) begin
          out_d      = {resHi_q, resLo_q};
          flags_d    = flgHi_q | flgLo_q;
          outValid_d = 1'b1;
        end else if (bus.out_ready) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      signLo_q   <= 1'b0;
      signHi_q   <= 1'b0;
      expLo_q    <= '0;
      expHi_q    <= '0;
      mantLo_q   <= '0;
      mantHi_q   <= '0;
      stickyLo_q <= 1'b0;
      stickyHi_q <= 1'b0;
      resLo_q    <= '0;
      resHi_q    <= '0;
      flgLo_q    <= '0;
      flgHi_q    <= '0;
      out_q      <= '0;
      flags_q    <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      signLo_q   <= signLo_d;
      signHi_q   <= signHi_d;
      expLo_q    <= expLo_d;
      expHi_q    <= expHi_d;
      mantLo_q   <= mantLo_d;
      mantHi_q   <= mantHi_d;
      stickyLo_q <= stickyLo_d;
      stickyHi_q <= stickyHi_d;
      resLo_q    <= resLo_d;
      resHi_q    <= resHi_d;
      flgLo_q    <= flgLo_d;
      flgHi_q    <= flgHi_d;
      out_q      <= out_d;
      flags_q    <= flags_d;
      outValid_q <= outValid_d;
    end
  end

endmodule

// File: tb/tb_fp16_pack_rnd.sv
// tb_fp16_pack_rnd
// Directed and randomized checks of fp16_pack_rnd: reset values, latency,
// rounding/overflow/underflow/zero cases, output hold under backpressure,
// and reset in the middle of a transaction.
module tb_fp16_pack_rnd;

  logic clk;
  logic rst_n;
  int   compareCount;
  int   failCount;

  fp16_pack_rnd_if bus ();

  fp16_pack_rnd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Last-resort guard so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Value-level reference: mantissa M with exponent E means M * 2^(E-15-20).
  // Quantise to 11 significant bits by integer division with remainder,
  // then apply the FP16 range rules.
  function automatic void modelLane(input logic s, input logic [7:0] e8, input logic [21:0] m,
                                    output logic [15:0] res, output logic [2:0] flg);
    int     e;
    int     p;
    int     shift;
    longint q;
    longint rem;
    longint half;
    if (m == 22'd0) begin
      res = {s, 15'h0000};
      flg = 3'b000;
      return;
    end
    p = 0;
    for (int i = 0; i < 22; i++) if (m[i]) p = i;
    e = int'($signed(e8)) + p - 20;
    rem = 0;
    if (p >= 10) begin
      shift = p - 10;
      q     = longint'(m) >> shift;
      rem   = longint'(m) - (q << shift);
      half  = (shift > 0) ? (longint'(1) << (shift - 1)) : 0;
      if (shift > 0 && (rem > half || (rem == half && (q % 2) == 1))) q++;
    end else begin
      q = longint'(m) << (10 - p);
    end
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e >= 31) begin
      res = {s, 5'h1F, 10'h000};
      flg = 3'b101;
    end else if (e <= 0) begin
      res = {s, 15'h0000};
      flg = 3'b011;
    end else begin
      res = {s, 5'(e), 10'(q - 1024)};
      flg = {2'b00, rem != 0};
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one operand pair for exactly one accepting edge.
  task automatic applyStimulus(input logic sLo, input logic [7:0] eLo, input logic [21:0] mLo,
                               input logic sHi, input logic [7:0] eHi, input logic [21:0] mHi);
    bus.sign_lo  = sLo;
    bus.exp_lo   = eLo;
    bus.mant_lo  = mLo;
    bus.sign_hi  = sHi;
    bus.exp_hi   = eHi;
    bus.mant_hi  = mHi;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid, bounded.
  task automatic waitValid(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 12) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic runTransaction(input string tag,
                                input logic sLo, input logic [7:0] eLo, input logic [21:0] mLo,
                                input logic sHi, input logic [7:0] eHi, input logic [21:0] mHi,
                                input logic [31:0] expOut, input logic [2:0] expFlags);
    int lat;
    applyStimulus(sLo, eLo, mLo, sHi, eHi, mHi);
    waitValid(lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'd5);
    checkOutput({tag, " out"}, bus.out, expOut);
    checkOutput({tag, " flags"}, {29'd0, bus.flags}, {29'd0, expFlags});
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
    checkOutput({tag, " in_ready back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] rLo, rHi;
    logic [2:0]  fLo, fHi;
    logic        sL, sH;
    logic [7:0]  eL, eH;
    logic [21:0] mL, mH;
    logic        sawValid;
    int          lat;

    compareCount  = 0;
    failCount     = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sign_lo   = 1'b0;
    bus.sign_hi   = 1'b0;
    bus.exp_lo    = 8'd0;
    bus.exp_hi    = 8'd0;
    bus.mant_lo   = 22'd0;
    bus.mant_hi   = 22'd0;
    rst_n         = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset out", bus.out, 32'd0);
    checkOutput("reset flags", {29'd0, bus.flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Directed vectors
    runTransaction("basic", 1'b0, 8'd15, 22'h100000, 1'b1, 8'd15, 22'h200000, 32'hC000_3C00, 3'b000);
    runTransaction("tie even", 1'b0, 8'd15, 22'h100200, 1'b0, 8'd15, 22'h100000, 32'h3C00_3C00, 3'b001);
    runTransaction("tie odd", 1'b0, 8'd15, 22'h100600, 1'b0, 8'd15, 22'h100000, 32'h3C00_3C02, 3'b001);
    runTransaction("ovf unf", 1'b0, 8'd31, 22'h100000, 1'b1, 8'd0, 22'h080000, 32'h8000_7C00, 3'b111);
    runTransaction("zero carry", 1'b1, 8'd20, 22'h000000, 1'b0, 8'd15, 22'h1FFE00, 32'h4000_8000, 3'b001);
    runTransaction("carry ovf", 1'b0, 8'd30, 22'h1FFE00, 1'b0, 8'd1, 22'h100000, 32'h0400_7C00, 3'b101);
    runTransaction("neg exp", 1'b0, 8'hF0, 22'h100000, 1'b0, 8'h7F, 22'h000001, 32'h7C00_0000, 3'b111);

    // Backpressure: result held, extra in_valid ignored
    applyStimulus(1'b0, 8'd15, 22'h140001, 1'b0, 8'd16, 22'h100000);
    waitValid(lat);
    checkOutput("hold latency", 32'(lat), 32'd5);
    bus.sign_lo  = 1'b1;
    bus.exp_lo   = 8'd20;
    bus.mant_lo  = 22'h155555;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold out c%0d", k), bus.out, 32'h4000_3D00);
      checkOutput($sformatf("hold flags c%0d", k), {29'd0, bus.flags}, 32'd1);
      checkOutput($sformatf("hold valid c%0d", k), {31'd0, bus.out_valid}, 32'd1);
      checkOutput($sformatf("hold in_ready c%0d", k), {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("hold release", {31'd0, bus.out_valid}, 32'd0);
    sawValid = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("ignored in_valid", {31'd0, sawValid}, 32'd0);

    // Reset while the lo lane is rounding
    applyStimulus(1'b1, 8'd18, 22'h0ABCDE, 1'b0, 8'd12, 22'h3FFFFF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out", bus.out, 32'd0);
    checkOutput("midreset flags", {29'd0, bus.flags}, 32'd0);
    checkOutput("midreset valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("midreset no pulse", {31'd0, sawValid}, 32'd0);
    checkOutput("midreset in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Randomized pairs against the reference model
    for (int n = 0; n < 40; n++) begin
      sL = 1'($urandom_range(0, 1));
      sH = 1'($urandom_range(0, 1));
      eL = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      eH = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      mL = 22'($urandom) >> $urandom_range(0, 22);
      mH = 22'($urandom) >> $urandom_range(0, 22);
      modelLane(sL, eL, mL, rLo, fLo);
      modelLane(sH, eH, mH, rHi, fHi);
      runTransaction($sformatf("rand%0d", n), sL, eL, mL, sH, eH, mH, {rHi, rLo}, fHi | fLo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/fp16_pack_rnd.md
FP16_PACK_RND -- requirements
Module: fp16_pack_rnd

Interface
REQ-001: clk  input  1  sole clock; all state updates on rising edge.
REQ-002: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003: in_valid  input  1  operand pair present on lane inputs.
REQ-004: in_ready  output  1  block can accept an operand pair.
REQ-005: sign_lo, sign_hi  input  1 each  lane sign (lo packs to bits [15:0], hi to bits [31:16]).
REQ-006: exp_lo, exp_hi  input  8 each  two's-complement biased exponent, bias 15.
REQ-007: mant_lo, mant_hi  input  22 each  unsigned product mantissa, format 2.20 (binary point between bits 20 and 19).
REQ-008: out_valid  output  1  packed result valid.
REQ-009: out_ready  input  1  consumer accepts the result.
REQ-010: out  output  32  {hi FP16, lo FP16} packed result.
REQ-011: flags  output  3  {overflow, underflow, inexact}, OR of both lanes, valid with out_valid.

Function
REQ-012: Handshake on each side: transfer only on a cycle with valid and ready both high.
REQ-013: in_ready SHALL be 1 only in IDLE; lane inputs are captured into internal registers on the accepting edge.
REQ-014: FSM states: IDLE, NORM0, RND0, NORM1, RND1, DONE; transitions IDLE->NORM0 on accept, then one state per cycle to DONE, DONE->IDLE on out_ready.
REQ-015: Latency: accept at edge T gives out_valid=1 after edge T+5; out, flags held stable while out_valid=1 and out_ready=0.
REQ-016: NORM: if mant[21]=1, shift right 1 and increment exponent (bit shifted out joins sticky); otherwise left-shift by leading-zero count so bit 20 is 1 and subtract that count from exponent; 10-bit internal exponent arithmetic, no wrap.
REQ-017: RND: kept significand = mant[20:10], guard = mant[9], sticky = OR mant[8:0] plus any NORM shifted-out bit; round-to-nearest-even.
REQ-018: Rounding carry out of bit 20 SHALL renormalise: significand 1.0, exponent +1.
REQ-019: Final exponent >= 31 -> lane = {sign, 0x7C00 field} (infinity), overflow=1, inexact=1.
REQ-020: Final exponent <= 0 -> lane = {sign, 15'h0} (flush, no subnormals), underflow=1, inexact=1 if mant nonzero.
REQ-021: mant == 0 -> lane = {sign, 15'h0}, no flags, regardless of exponent.
REQ-022: Otherwise lane = {sign, exp[4:0], significand[9:0]}; inexact=1 if guard or sticky set.
REQ-023: in_valid while not IDLE SHALL be ignored (no capture, no state change).
REQ-024: out_valid SHALL deassert on the edge where out_ready=1 in DONE; earliest next accept is the following cycle.

Reset
REQ-025: rst_n=0 SHALL immediately force state IDLE, out_valid=0, out=0, flags=0, in_ready=1 after release.
REQ-026: Reset mid-operation SHALL discard the in-flight pair; no out_valid pulse follows release.
REQ-027: All internal lane registers SHALL clear to 0 on reset.

Verification
REQ-028: lo: s=0 exp=15 mant=0x100000; hi: s=1 exp=15 mant=0x200000 -> out=0xC0003C00 at T+5, flags=000.
REQ-029: lo mant=0x100200 exp=15 (tie, even) -> lo=0x3C00 inexact=1; lo mant=0x100600 -> lo=0x3C02 inexact=1.
REQ-030: lo exp=31 mant=0x100000 -> 0x7C00 overflow=1; hi exp=0 mant=0x080000 s=1 -> 0x8000 underflow=1.
REQ-031: lo mant=0x000000 s=1 exp=20 -> lo=0x8000, flags=000; lo mant=0x1FFE00 exp=15 -> rounds to 0x4000, inexact=1.
REQ-032: Hold out_ready=0 for 4 cycles in DONE -> out stable, in_ready=0, extra in_valid ignored; then out_ready=1 -> out_valid low next edge.
REQ-033: Assert rst_n=0 during RND0 -> outputs zero immediately; after release no out_valid until a new accept.
